// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM port arbiter.
//   num          - signed 16-bit data word carried to and from the SRAM
//   arb_state_t  - arbiter FSM states
//   SRAM_ADDR_W  - default SRAM word address width
//   TIMEOUT_MAX  - ACCESS cycles allowed before the watchdog aborts
//                  (only used when SRAM_ARB_TIMEOUT_EN is defined)
package sram_pkg;

    typedef logic signed [15:0] num;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    localparam int SRAM_ADDR_W = 21;
    localparam int TIMEOUT_MAX = 255;

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// The search starts at the client after last_grant and wraps, so the most
// recently served client has the lowest priority.
// Ports:
//   req        in   N        request vector
//   last_grant in   IDX_W    index of the client served last
//   winner     out  IDX_W    index of the selected client (0 when none)
//   any_req    out  1        at least one request present
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int cand_s;

    // Walk the candidates in priority order; the first one requesting wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand_s  = 0;
        for (int i = 1; i <= N; i++) begin
            cand_s = (int'(last_grant) + i) % N;
            for (int j = 0; j < N; j++) begin
                if (!any_req && (j == cand_s) && req[j]) begin
                    winner  = IDX_W'(j);
                    any_req = 1'b1;
                end else begin
                    any_req = any_req;
                end
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port between N_CLIENTS
// requesters with round-robin arbitration. One transaction is in flight
// at a time; every output is registered and always driven.
// Optional build macro: SRAM_ARB_TIMEOUT_EN adds an ACCESS watchdog and
// the sticky timeout_err output.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cl_req/cl_we          per-client request and write enable (0 = read)
//   cl_addr/cl_wdata      packed per-client address and write data
//   cl_ack                one-cycle completion pulse to the granted client
//   cl_rdata              read data, valid in the cl_ack cycle
//   sram_ready/sram_rdata controller completion and read data
//   sram_read/sram_write  strobes held for the whole access
//   sram_addr/sram_wdata  address and write data of the access
//   busy                  high while in ACCESS or ACK
//   timeout_err           sticky watchdog flag (SRAM_ARB_TIMEOUT_EN only)
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int N_CLIENTS = 3,
    parameter int ADDR_W    = SRAM_ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        cl_req,
    input  logic [N_CLIENTS-1:0]        cl_we,
    input  logic [N_CLIENTS*ADDR_W-1:0] cl_addr,
    input  logic [N_CLIENTS*16-1:0]     cl_wdata,
    output logic [N_CLIENTS-1:0]        cl_ack,
    output logic [15:0]                 cl_rdata,
    input  logic                        sram_ready,
    input  logic [15:0]                 sram_rdata,
    output logic                        sram_read,
    output logic                        sram_write,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic [15:0]                 sram_wdata,
    output logic                        busy
`ifdef SRAM_ARB_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);

    localparam int IDX_W = $clog2(N_CLIENTS);

`ifdef SRAM_ARB_TIMEOUT_EN
    // The counter starts at 0 in the first ACCESS cycle, so this value
    // marks the last permitted cycle.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_MAX - 1);
    logic [7:0] wdog_r;
`endif

    arb_state_t         state_r;
    logic [IDX_W-1:0]   gnt_idx_r;
    logic [IDX_W-1:0]   last_grant_r;
    logic [IDX_W-1:0]   winner_s;
    logic               any_req_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [15:0]        sel_wdata_s;
    logic               sel_we_s;
    logic [N_CLIENTS-1:0] ack_vec_s;

    rr_pick #(
        .N     (N_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (cl_req),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_req    (any_req_s)
    );

    // Select the winning client's address, data and direction.
    always_comb begin
        sel_addr_s  = cl_addr[ADDR_W-1:0];
        sel_wdata_s = cl_wdata[15:0];
        sel_we_s    = cl_we[0];
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (winner_s == IDX_W'(i)) begin
                sel_addr_s  = cl_addr[i*ADDR_W +: ADDR_W];
                sel_wdata_s = cl_wdata[i*16 +: 16];
                sel_we_s    = cl_we[i];
            end else begin
                sel_we_s = sel_we_s;
            end
        end
    end

    // One-hot acknowledge vector for the client currently holding the grant.
    always_comb begin
        ack_vec_s = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            ack_vec_s[i] = (gnt_idx_r == IDX_W'(i));
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            gnt_idx_r    <= '0;
            last_grant_r <= IDX_W'(N_CLIENTS - 1);
            cl_ack       <= '0;
            cl_rdata     <= 16'h0000;
            sram_read    <= 1'b0;
            sram_write   <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= 16'h0000;
            busy         <= 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            wdog_r       <= 8'd0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    cl_ack <= '0;
                    if (any_req_s) begin
                        gnt_idx_r  <= winner_s;
                        sram_addr  <= sel_addr_s;
                        sram_wdata <= sel_wdata_s;
                        sram_read  <= ~sel_we_s;
                        sram_write <= sel_we_s;
                        busy       <= 1'b1;
                        state_r    <= ACCESS;
`ifdef SRAM_ARB_TIMEOUT_EN
                        wdog_r     <= 8'd0;
`endif
                    end else begin
                        sram_read  <= 1'b0;
                        sram_write <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (sram_ready) begin
                        sram_read    <= 1'b0;
                        sram_write   <= 1'b0;
                        // The read strobe still identifies the direction here.
                        if (sram_read) begin
                            cl_rdata <= sram_rdata;
                        end else begin
                            cl_rdata <= cl_rdata;
                        end
                        cl_ack       <= ack_vec_s;
                        last_grant_r <= gnt_idx_r;
                        state_r      <= ACK;
                    end else begin
`ifdef SRAM_ARB_TIMEOUT_EN
                        if (wdog_r == WDOG_LAST) begin
                            // Abort: hand back the most negative num so the
                            // client sees an obviously invalid value.
                            sram_read    <= 1'b0;
                            sram_write   <= 1'b0;
                            cl_rdata     <= 16'h8000;
                            cl_ack       <= ack_vec_s;
                            last_grant_r <= gnt_idx_r;
                            timeout_err  <= 1'b1;
                            state_r      <= ACK;
                        end else begin
                            wdog_r <= wdog_r + 8'd1;
                        end
`else
                        state_r <= ACCESS;
`endif
                    end
                end
                ACK: begin
                    // Gives the client a cycle to drop cl_req before rearbitration.
                    cl_ack  <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    cl_ack     <= '0;
                    sram_read  <= 1'b0;
                    sram_write <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter (3 clients, 21-bit addresses).
// Stimulus fills per-client transaction queues; a transaction-level
// round-robin model predicts the service order and pushes the expected
// accesses into a queue that an independent monitor pops and compares.
module tb_sram_arbiter;

    typedef struct {
        int          client;
        logic        we;
        logic [20:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          tmo;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  cl_req, cl_we, cl_ack;
    logic [62:0] cl_addr;
    logic [47:0] cl_wdata;
    logic [15:0] cl_rdata, sram_rdata, sram_wdata;
    logic        sram_ready, sram_read, sram_write, busy;
    logic [20:0] sram_addr;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    sram_arbiter #(.N_CLIENTS(3), .ADDR_W(21)) dut (
        .clk        (clk),
        .reset      (reset),
        .cl_req     (cl_req),
        .cl_we      (cl_we),
        .cl_addr    (cl_addr),
        .cl_wdata   (cl_wdata),
        .cl_ack     (cl_ack),
        .cl_rdata   (cl_rdata),
        .sram_ready (sram_ready),
        .sram_rdata (sram_rdata),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .busy       (busy)
`ifdef SRAM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failed = 0;

    // client-side transaction queues
    txn_t ctx [3][256];
    int   chead [3];
    int   ctail [3];
    int   mhead [3];

    // scoreboard and model state
    txn_t exp_q [$];
    txn_t cur;
    bit   in_flight = 1'b0;
    int   p_model = 2;
    logic [15:0] m_last = 16'h0000;
    bit   tmo_mode = 1'b0;

    // SRAM responder configuration
    bit   resp_en = 1'b1;
    bit   spur_en = 1'b0;
    int   force_delay = -1;
    bit   ovr_en = 1'b0;
    logic [15:0] ovr_data = 16'h0000;
    int   ready_cyc = 0;

    // monitor records
    int   grant_q [$];
    int   ack_cyc_q [$];
    int   last_strobe_len = 0;
    int   last_ack_client = -1;

    function automatic logic [15:0] fdat(input logic [20:0] a);
        return a[15:0] ^ 16'hC3A5 ^ {11'd0, a[20:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic enq(input int c, input logic we, input logic [20:0] addr, input logic [15:0] wd);
        ctx[c][ctail[c]].client = c;
        ctx[c][ctail[c]].we     = we;
        ctx[c][ctail[c]].addr   = addr;
        ctx[c][ctail[c]].wdata  = wd;
        ctail[c]++;
    endtask

    task automatic exp_push(input int c, input logic we, input logic [20:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd_read, input bit tmo);
        txn_t e;
        e.client = c; e.we = we; e.addr = addr; e.wdata = wd; e.tmo = tmo;
        if (tmo) m_last = 16'h8000;
        else if (!we) m_last = rd_read;
        e.rdata = m_last;
        p_model = c;
        exp_q.push_back(e);
    endtask

    // Round-robin service over every client that still has queued work.
    task automatic model_rr();
        int rem [3];
        int idx [3];
        int total;
        int c;
        txn_t t;
        total = 0;
        for (int k = 0; k < 3; k++) begin
            rem[k] = ctail[k] - mhead[k];
            idx[k] = mhead[k];
            total += rem[k];
        end
        while (total > 0) begin
            for (int s = 1; s <= 3; s++) begin
                c = (p_model + s) % 3;
                if (rem[c] > 0) begin
                    t = ctx[c][idx[c]];
                    exp_push(c, t.we, t.addr, t.wdata, ovr_en ? ovr_data : fdat(t.addr), tmo_mode);
                    idx[c]++; rem[c]--; total--;
                    break;
                end
            end
        end
        for (int k = 0; k < 3; k++) mhead[k] = ctail[k];
    endtask

    function automatic bit all_empty();
        return (chead[0] == ctail[0]) && (chead[1] == ctail[1]) && (chead[2] == ctail[2]);
    endfunction

    task automatic flush_model();
        exp_q.delete();
        in_flight = 1'b0;
        for (int k = 0; k < 3; k++) begin chead[k] = ctail[k]; mhead[k] = ctail[k]; end
        p_model = 2;
        m_last = 16'h0000;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        flush_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !in_flight && all_empty()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            failed++;
            $display("FAIL %s: not drained after %0d cycles, %0d expected left", name, n, exp_q.size());
            pulse_reset();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int n = 0;
        while (!(sram_read || sram_write) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            failed++;
            $display("FAIL %s: no strobe after %0d cycles, wanted 1", name, n);
        end
    endtask

    // Client agents: raise a request with the queue head, drop it on cl_ack.
    initial begin
        cl_req = 3'b000; cl_we = 3'b000; cl_addr = '0; cl_wdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cl_req = 3'b000;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (cl_req[c]) begin
                        if (cl_ack[c]) begin
                            cl_req[c] = 1'b0;
                            chead[c]++;
                        end
                    end else if (chead[c] != ctail[c]) begin
                        cl_we[c]              = ctx[c][chead[c]].we;
                        cl_addr[c*21 +: 21]   = ctx[c][chead[c]].addr;
                        cl_wdata[c*16 +: 16]  = ctx[c][chead[c]].wdata;
                        cl_req[c]             = 1'b1;
                    end
                end
            end
        end
    end

    // SRAM controller model: answer each strobe after a delay, sometimes
    // assert a stray ready while no access is in progress.
    initial begin
        int wait_cnt;
        bit served;
        wait_cnt = -1; served = 1'b0;
        sram_ready = 1'b0; sram_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            sram_ready = 1'b0;
            sram_rdata = 16'($urandom);
            if (reset) begin
                served = 1'b0; wait_cnt = -1;
            end else if (sram_read || sram_write) begin
                if (!served && resp_en) begin
                    if (wait_cnt < 0) wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                    if (wait_cnt == 0) begin
                        sram_ready = 1'b1;
                        if (sram_read) sram_rdata = ovr_en ? ovr_data : fdat(sram_addr);
                        ready_cyc = cyc;
                        served = 1'b1;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                served = 1'b0; wait_cnt = -1;
                if (spur_en && $urandom_range(0, 3) == 0) sram_ready = 1'b1;
            end
        end
    end

    // Monitor: pop expectations when an access starts, check the ack.
    initial begin
        bit prev_strobe, prev_ack, strobe_now;
        int start_cyc, strobe_cnt, who;
        prev_strobe = 1'b0; prev_ack = 1'b0; start_cyc = 0; strobe_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_strobe = 1'b0; prev_ack = 1'b0;
            end else begin
                strobe_now = sram_read | sram_write;
                chk("busy", {31'd0, busy}, {31'd0, strobe_now | (|cl_ack)});
                if (prev_ack) chk("ack_pulse", {29'd0, cl_ack}, 32'd0);
                if (strobe_now && !prev_strobe) begin
                    if (exp_q.size() == 0) begin
                        tests++; failed++;
                        $display("FAIL start: unexpected access at addr %0h, expected none", sram_addr);
                    end else begin
                        cur = exp_q.pop_front();
                        in_flight = 1'b1;
                        start_cyc = cyc;
                        strobe_cnt = 0;
                        chk("start_wdata", {16'd0, sram_wdata}, {16'd0, cur.wdata});
                    end
                end
                if (strobe_now && in_flight) begin
                    strobe_cnt++;
                    chk("hold_addr", {11'd0, sram_addr}, {11'd0, cur.addr});
                    chk("hold_rw", {30'd0, sram_write, sram_read}, cur.we ? 32'd2 : 32'd1);
                end
                if (cl_ack != 3'b000) begin
                    if (!in_flight) begin
                        tests++; failed++;
                        $display("FAIL ack: unexpected cl_ack %b, expected 000", cl_ack);
                    end else begin
                        chk("ack_vec", {29'd0, cl_ack}, 32'd1 << cur.client);
                        chk("rdata", {16'd0, cl_rdata}, {16'd0, cur.rdata});
                        if (cur.tmo) begin
                            chk("tmo_len", strobe_cnt, 32'd255);
                        end else begin
                            chk("ack_latency", cyc, ready_cyc + 1);
                            chk("strobe_len", strobe_cnt, ready_cyc - start_cyc + 1);
                        end
                        who = -1;
                        for (int k = 0; k < 3; k++) if (cl_ack[k]) who = k;
                        grant_q.push_back(who);
                        ack_cyc_q.push_back(cyc);
                        last_strobe_len = strobe_cnt;
                        last_ack_client = who;
                        in_flight = 1'b0;
                    end
                end
                prev_strobe = strobe_now;
                prev_ack = |cl_ack;
            end
        end
    end

    // Directed scenarios followed by randomized rounds.
    initial begin
        int mask;
        logic [20:0] a0, a1, a2;
        for (int k = 0; k < 3; k++) begin chead[k] = 0; ctail[k] = 0; mhead[k] = 0; end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack", {29'd0, cl_ack}, 32'd0);
        chk("rst_rdata", {16'd0, cl_rdata}, 32'd0);
        chk("rst_read", {31'd0, sram_read}, 32'd0);
        chk("rst_write", {31'd0, sram_write}, 32'd0);
        chk("rst_addr", {11'd0, sram_addr}, 32'd0);
        chk("rst_wdata", {16'd0, sram_wdata}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // single read from client 1, ready in the second strobe cycle
        force_delay = 1; ovr_en = 1'b1; ovr_data = 16'h1234;
        enq(1, 1'b0, 21'h0000A, 16'h0000);
        model_rr();
        wait_drain(50, "t1_drain");
        chk("t1_read_len", last_strobe_len, 32'd2);
        chk("t1_rdata", {16'd0, cl_rdata}, 32'h1234);
        chk("t1_client", last_ack_client, 32'd1);
        ovr_en = 1'b0;

        // write from client 0 leaves cl_rdata unchanged
        enq(0, 1'b1, 21'h00004, 16'hFF9C);
        model_rr();
        wait_drain(50, "t2_drain");
        chk("t2_rdata_kept", {16'd0, cl_rdata}, 32'h1234);
        chk("t2_client", last_ack_client, 32'd0);

        // reset in the middle of an access
        resp_en = 1'b0; force_delay = -1;
        enq(1, 1'b0, 21'h1F0F0, 16'h0000);
        model_rr();
        wait_strobe(20, "t3_strobe");
        #2 reset = 1'b1;
        #1;
        chk("t3_ack", {29'd0, cl_ack}, 32'd0);
        chk("t3_rdata", {16'd0, cl_rdata}, 32'd0);
        chk("t3_read", {31'd0, sram_read}, 32'd0);
        chk("t3_write", {31'd0, sram_write}, 32'd0);
        chk("t3_addr", {11'd0, sram_addr}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd0);
        flush_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);

        // all clients busy, immediate ready: strict rotation from client 0
        force_delay = 0;
        grant_q.delete(); ack_cyc_q.delete();
        for (int n = 0; n < 2; n++)
            for (int c = 0; c < 3; c++)
                enq(c, 1'($urandom_range(0, 1)), 21'($urandom), 16'($urandom));
        model_rr();
        wait_drain(100, "rr_drain");
        chk("rr_count", grant_q.size(), 32'd6);
        for (int i = 0; i < grant_q.size(); i++) chk("rr_order", grant_q[i], i % 3);
        for (int i = 1; i < ack_cyc_q.size(); i++) chk("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 32'd3);

        // client 2 arrives during client 0's access and is served next
        force_delay = 3;
        grant_q.delete();
        a0 = 21'h00100; a1 = 21'h00200; a2 = 21'h00300;
        enq(0, 1'b0, a0, 16'h1111);
        enq(0, 1'b0, a1, 16'h2222);
        exp_push(0, 1'b0, a0, 16'h1111, fdat(a0), 1'b0);
        exp_push(2, 1'b0, a2, 16'h3333, fdat(a2), 1'b0);
        exp_push(0, 1'b0, a1, 16'h2222, fdat(a1), 1'b0);
        mhead[0] = ctail[0];
        wait_strobe(20, "late_strobe");
        enq(2, 1'b0, a2, 16'h3333);
        mhead[2] = ctail[2];
        wait_drain(100, "late_drain");
        chk("late_count", grant_q.size(), 32'd3);
        for (int i = 0; i < grant_q.size(); i++) chk("late_order", grant_q[i], (i == 1) ? 32'd2 : 32'd0);

        // randomized rounds with random latency and stray ready pulses
        force_delay = -1; spur_en = 1'b1;
        for (int r = 0; r < 25; r++) begin
            mask = $urandom_range(1, 7);
            for (int c = 0; c < 3; c++)
                if (mask[c]) begin
                    int n_t;
                    n_t = $urandom_range(1, 3);
                    for (int k = 0; k < n_t; k++)
                        enq(c, 1'($urandom_range(0, 1)), 21'($urandom), 16'($urandom));
                end
            model_rr();
            wait_drain(400, "rand_drain");
        end
        spur_en = 1'b0;

`ifdef SRAM_ARB_TIMEOUT_EN
        // watchdog abort when the controller never answers
        chk("tmo_err_idle", {31'd0, timeout_err}, 32'd0);
        resp_en = 1'b0; tmo_mode = 1'b1;
        enq(1, 1'b0, 21'h00ABC, 16'h0000);
        model_rr();
        wait_drain(400, "tmo_drain");
        tmo_mode = 1'b0; resp_en = 1'b1;
        chk("tmo_rdata", {16'd0, cl_rdata}, 32'h8000);
        chk("tmo_err_set", {31'd0, timeout_err}, 32'd1);
        enq(2, 1'b1, 21'h00055, 16'h0F0F);
        model_rr();
        wait_drain(50, "tmo_after");
        chk("tmo_err_sticky", {31'd0, timeout_err}, 32'd1);
        pulse_reset();
        #1;
        chk("tmo_err_reset", {31'd0, timeout_err}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation ran past limit, expected to finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port between up to N_CLIENTS requesters: senone scorer, UART receive writer, score sender.
- Replaces tri-state sharing of read_data/data_addr with an explicit round-robin arbiter and muxed, always-driven SRAM signals.
- Sits between the client FSMs and the SRAM controller; one SRAM transaction in flight at a time.

Parameters:
- N_CLIENTS, 3: number of requesters, 2..8.
- ADDR_W, 21: SRAM word address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cl_req  in  N_CLIENTS  per-client request; held high until matching cl_ack
- cl_we  in  N_CLIENTS  per-client write enable; 0 = read
- cl_addr  in  N_CLIENTS*ADDR_W  packed addresses; client i at [i*ADDR_W +: ADDR_W]
- cl_wdata  in  N_CLIENTS*16  packed write data (num)
- cl_ack  out  N_CLIENTS  one-cycle completion pulse to the granted client
- cl_rdata  out  16  registered read data; valid in the cl_ack cycle
- sram_ready  in  1  SRAM controller transaction complete; data_in valid for reads
- sram_rdata  in  16  SRAM read data (num)
- sram_read  out  1  read strobe
- sram_write  out  1  write strobe
- sram_addr  out  ADDR_W  address
- sram_wdata  out  16  write data
- busy  out  1  high in ACCESS and ACK states

Behaviour:
- Reset values: cl_ack=0, cl_rdata=0, sram_read=0, sram_write=0, sram_addr=0, sram_wdata=0, busy=0, state=IDLE, last_grant=N_CLIENTS-1 (client 0 wins first).
- All outputs are registered and always driven; no Z.
- FSM states:
  - IDLE: if any cl_req, pick the winner by round-robin search starting at last_grant+1 mod N_CLIENTS.
    - Latch gnt_idx.
    - Load sram_addr and sram_wdata from the winner.
    - Set sram_read=~cl_we[w] and sram_write=cl_we[w].
    - Go to ACCESS. No request: stay in IDLE, strobes 0.
  - ACCESS: hold strobes, address and data stable. On sram_ready:
    - Clear both strobes.
    - Capture cl_rdata<=sram_rdata (reads only; unchanged on writes).
    - Set cl_ack[gnt_idx]=1, last_grant<=gnt_idx.
    - Go to ACK.
  - ACK: clear cl_ack, go to IDLE. This cycle lets the client drop cl_req before the next arbitration.
- Latency: cl_req high at edge k → strobe at k+1. With sram_ready at cycle j ≥ k+1, cl_ack is high in cycle j+1.
- Best-case cycle: 3 clocks per transaction (IDLE→ACCESS→ACK).
- Arbitration happens only in IDLE; requests arriving during ACCESS/ACK wait. Simultaneous requests resolve strictly by the round-robin order.
- Fairness: with all clients requesting, no client waits more than N_CLIENTS-1 transactions.
- Client deasserts cl_req mid-ACCESS (protocol violation): the transaction still completes and cl_ack still pulses.
- sram_ready while in IDLE or ACK: ignored.
- Reset mid-ACCESS: strobes drop asynchronously, no ack issued, and the pointer returns to its reset value.
- A single client with continuous cl_req is re-granted every 3 cycles.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN
- Enabled:
  - 8-bit watchdog counts cycles in ACCESS.
  - At 255 without sram_ready: abort, set cl_rdata=16'h8000 (most-negative num), pulse cl_ack, go to ACK.
  - Set sticky output port timeout_err (1 bit, reset 0), cleared only by reset.
- Disabled: no counter and no timeout_err port; ACCESS waits indefinitely.

Decomposition:
- Package sram_pkg:
  - typedef num (logic signed [15:0]);
  - typedef arb_state_t {IDLE, ACCESS, ACK};
  - constant SRAM_ADDR_W=21;
  - constant TIMEOUT_MAX=255.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Instantiated once; unit-testable on its own.

Test Plan:
- Single read: client 1 req, we=0, addr=21'h000A; sram_ready 2 cycles after strobe with sram_rdata=16'h1234 → sram_read high 2 cycles, sram_addr=0x0A, cl_ack=3'b010 one cycle, cl_rdata=0x1234.
- Write: client 0 req, we=1, addr=0x0004, wdata=16'hFF9C (-100) → sram_write=1, sram_wdata=0xFF9C, cl_ack[0] pulse, cl_rdata unchanged.
- Round-robin: all 3 clients request continuously, sram_ready immediate → grant order 0,1,2,0,1,2; acks spaced 3 cycles apart.
- Late arrival: client 2 requests during client 0's ACCESS → client 2 served next, before a re-request from client 0.
- Reset mid-ACCESS: assert reset while sram_read=1 → all outputs 0 immediately, no cl_ack; after release client 0 wins first.
- With SRAM_ARB_TIMEOUT_EN, sram_ready never asserted → cl_ack after 255 ACCESS cycles, cl_rdata=0x8000, timeout_err=1 held until reset.
